// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a registered carry, LSB first,
// one bit per clock, wrapped in a start/busy/done handshake.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             ci_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res_sr;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_co;
    logic             r_busy;
    logic             r_done;

    logic             w_s;
    logic             w_co;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

    always_comb begin
        w_s        = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
        w_co       = (r_a_sr[0] & r_b_sr[0]) | (r_carry & (r_a_sr[0] ^ r_b_sr[0]));
        // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at LSB.
        w_res_next            = r_res_sr >> 1;
        w_res_next[WIDTH-1]   = w_s;
        w_last     = (r_cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_sum    <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_co     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr   <= a_in;
                        r_b_sr   <= b_in;
                        r_carry  <= ci_in;
                        r_cnt    <= '0;
                        r_res_sr <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_res_sr <= w_res_next;
                    r_carry  <= w_co;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_sum   <= w_res_next;
                        r_co    <= w_co;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign co   = r_co;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: a WIDTH=8 instance against a cycle-level handshake
// model, plus a WIDTH=1 instance driven through the full-adder truth table.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;

    logic         start8;
    logic [W-1:0] a8, b8;
    logic         ci8;
    logic         busy8, done8, co8;
    logic [W-1:0] sum8;

    logic         start1;
    logic [0:0]   a1, b1, sum1;
    logic         ci1, busy1, done1, co1;

    serial_adder #(.WIDTH(W)) u_w8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a_in  (a8),
        .b_in  (b8),
        .ci_in (ci8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .co    (co8)
    );

    serial_adder #(.WIDTH(1)) u_w1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a_in  (a1),
        .b_in  (b1),
        .ci_in (ci1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .co    (co1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: remaining busy cycles after an accept, and the pending result.
    int           m_rem;
    logic [W:0]   m_pend;
    logic [W-1:0] m_sum;
    logic         m_co;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] s;
        logic         c;
    } vec8_t;

    typedef struct {
        logic       a;
        logic       b;
        logic       ci;
        logic [1:0] cs;
    } vec1_t;

    vec8_t tbl8[5];
    vec1_t tbl1[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            m_rem = 0;
            m_sum = '0;
            m_co  = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 1) {m_co, m_sum} = m_pend;
        end else if (start8) begin
            m_pend = {1'b0, a8} + {1'b0, b8} + {{W{1'b0}}, ci8};
            m_rem  = W + 1;
        end
        #1;
        chk("busy", 32'(busy8), 32'(m_rem > 0));
        chk("done", 32'(done8), 32'(m_rem == 1));
        chk("sum",  32'(sum8),  32'(m_sum));
        chk("co",   32'(co8),   32'(m_co));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        tbl8[2] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        tbl8[3] = '{8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0};
        tbl8[4] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0};
        tbl1[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
        tbl1[1] = '{1'b0, 1'b0, 1'b1, 2'b01};
        tbl1[2] = '{1'b0, 1'b1, 1'b0, 2'b01};
        tbl1[3] = '{1'b0, 1'b1, 1'b1, 2'b10};
        tbl1[4] = '{1'b1, 1'b0, 1'b0, 2'b01};
        tbl1[5] = '{1'b1, 1'b0, 1'b1, 2'b10};
        tbl1[6] = '{1'b1, 1'b1, 1'b0, 2'b10};
        tbl1[7] = '{1'b1, 1'b1, 1'b1, 2'b11};

        m_rem = 0; m_sum = '0; m_co = 1'b0; m_pend = '0;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;

        // Reset state, with start asserted to confirm nothing is captured.
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
        cyc();
        cyc();
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_sum",  32'(sum8),  32'd0);
        chk("rst_w1_busy", 32'(busy1), 32'd0);
        rst = 1'b0; start8 = 1'b0;
        cyc();

        // Directed vectors; operands scrambled after capture.
        for (int i = 0; i < 5; i++) begin
            a8 = tbl8[i].a; b8 = tbl8[i].b; ci8 = tbl8[i].ci; start8 = 1'b1;
            cyc();
            start8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
            for (int k = 1; k <= int'(W) + 1; k++) begin
                cyc();
                if (k == int'(W)) begin
                    chk("tbl_done", 32'(done8), 32'd1);
                    chk("tbl_sum",  32'(sum8),  32'(tbl8[i].s));
                    chk("tbl_co",   32'(co8),   32'(tbl8[i].c));
                end
            end
            chk("tbl_idle", 32'(busy8), 32'd0);
        end

        // Reset in the middle of a run: outputs clear without waiting for an edge.
        a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b0; start8 = 1'b1;
        cyc();
        start8 = 1'b0;
        repeat (4) cyc();
        #2 rst = 1'b1;
        m_rem = 0; m_sum = '0; m_co = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy8), 32'd0);
        chk("midrst_done", 32'(done8), 32'd0);
        chk("midrst_sum",  32'(sum8),  32'd0);
        chk("midrst_co",   32'(co8),   32'd0);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        cyc();
        rst = 1'b0; start8 = 1'b0;
        repeat (3) cyc();
        a8 = 8'h01; b8 = 8'h01; ci8 = 1'b0; start8 = 1'b1;
        cyc();
        start8 = 1'b0;
        repeat (W + 1) cyc();
        chk("postrst_sum", 32'(sum8), 32'h02);
        chk("postrst_co",  32'(co8),  32'd0);

        // Back-to-back: start raised during done; previous result held through the new run.
        a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0; start8 = 1'b1;
        cyc();
        start8 = 1'b0;
        repeat (W) cyc();
        chk("b2b_done", 32'(done8), 32'd1);
        a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b1; start8 = 1'b1;
        cyc();
        chk("b2b_not_in_done", 32'(busy8), 32'd0);
        cyc();
        start8 = 1'b0;
        chk("b2b_accept", 32'(busy8), 32'd1);
        chk("b2b_hold0", 32'(sum8), 32'h30);
        repeat (W - 1) cyc();
        chk("b2b_hold1", 32'(sum8), 32'h30);
        cyc();
        chk("b2b_sum", 32'(sum8), 32'h81);
        chk("b2b_co",  32'(co8),  32'd0);
        repeat (2) cyc();

        // Start held high with fresh operands each cycle.
        start8 = 1'b1;
        repeat (60) begin
            a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
            cyc();
        end
        start8 = 1'b0;
        repeat (W + 2) cyc();

        // Random start/operand traffic.
        repeat (400) begin
            start8 = ($urandom_range(0, 3) == 0);
            a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
            cyc();
        end
        start8 = 1'b0;
        repeat (W + 2) cyc();

        // WIDTH=1 instance: full-adder truth table, done one cycle after accept.
        for (int i = 0; i < 8; i++) begin
            a1 = tbl1[i].a; b1 = tbl1[i].b; ci1 = tbl1[i].ci; start1 = 1'b1;
            cyc();
            start1 = 1'b0; a1 = ~a1; b1 = ~b1; ci1 = ~ci1;
            chk("w1_busy", 32'(busy1), 32'd1);
            chk("w1_nodone", 32'(done1), 32'd0);
            cyc();
            chk("w1_done", 32'(done1), 32'd1);
            chk("w1_cosum", 32'({co1, sum1}), 32'(tbl1[i].cs));
            cyc();
            chk("w1_idle", 32'(busy1), 32'd0);
            chk("w1_hold", 32'({co1, sum1}), 32'(tbl1[i].cs));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
